serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 83 ++++++++
 tb/tb_serial_subtractor.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// WIDTH clocks per operation with a valid/ready handshake on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] areg, breg, dreg;
  logic [CW-1:0]    cnt;
  logic             brw, bout_q;
  logic             accept, d, brw_next;

  assign d        = areg[0] ^ breg[0] ^ brw;
  assign brw_next = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & brw);

  assign bus.diff = dreg;
  assign bus.bout = bout_q;
  assign bus.zero = (state == HOLD) && (dreg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_next = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg   <= '0;
      breg   <= '0;
      dreg   <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
    end else if (accept) begin
      areg   <= bus.a;
      breg   <= bus.b;
      brw    <= bus.bin;
      cnt    <= '0;
      bout_q <= 1'b0;
    end else if (state == RUN) begin
      dreg <= {d, dreg[WIDTH-1:1]};
      areg <= areg >> 1;
      breg <= breg >> 1;
      brw  <= brw_next;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) bout_q <= brw_next;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic model
// (WIDTH=8 instance plus an exhaustive WIDTH=3 instance).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(3)) bus3 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  always #5 clk = ~clk;

  function automatic int unsigned ref_diff(int unsigned a, int unsigned b, int unsigned bin, int w);
    return (a - b - bin) & ((32'd1 << w) - 1);
  endfunction

  function automatic logic ref_bout(int unsigned a, int unsigned b, int unsigned bin);
    return (a < b + bin) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input int hold, output logic [7:0] diff, output logic bout,
                         output logic zero, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus8.in_ready && guard < 30) begin @(negedge clk); guard++; end
    if (guard >= 30) begin
      checks++; errors++;
      $display("[TB] FAIL ready8 in_ready stuck got 0 exp 1");
    end
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    lat = 0;
    while (!bus8.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    diff = bus8.diff; bout = bus8.bout; zero = bus8.zero;
    repeat (hold) begin @(posedge clk); #1; end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic run_op3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                         output logic [2:0] diff, output logic bout, output int lat);
    @(negedge clk);
    bus3.a = a; bus3.b = b; bus3.bin = bin; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    bus3.a = 3'($urandom); bus3.b = 3'($urandom);
    lat = 0;
    while (!bus3.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    diff = bus3.diff; bout = bus3.bout;
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.diff, bus8.bout, bus8.zero} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset8 got rdy=%b vld=%b diff=%h bout=%b zero=%b exp rdy=1 vld=0 diff=00 bout=0 zero=0",
               bus8.in_ready, bus8.out_valid, bus8.diff, bus8.bout, bus8.zero);
    end
    checks++;
    if ({bus3.in_ready, bus3.out_valid, bus3.diff, bus3.bout} !== {1'b1, 1'b0, 3'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset3 got rdy=%b vld=%b diff=%h bout=%b exp 1 0 0 0",
               bus3.in_ready, bus3.out_valid, bus3.diff, bus3.bout);
    end
  endtask

  // Operands already presented when reset releases, so the first edge must accept.
  task automatic test_first_accept();
    int lat = 1;
    bus8.a = 8'd5; bus8.b = 8'd3; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL first_accept in_ready got %b exp 0", bus8.in_ready);
    end
    while (!bus8.out_valid && lat < 30) begin
      @(posedge clk); #1;
      if (!bus8.out_valid) lat++;
    end
    checks++;
    if (lat !== 8) begin errors++; $display("[TB] FAIL first_latency got %0d exp 8", lat); end
    checks++;
    if ({bus8.diff, bus8.bout, bus8.zero} !== {8'h02, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL first_result got %h/%b/%b exp 02/0/0", bus8.diff, bus8.bout, bus8.zero);
    end
    bus8.out_ready = 1'b1; @(posedge clk); #1; bus8.out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] av[4] = '{8'h03, 8'h00, 8'hFF, 8'h80};
    logic [7:0] bv[4] = '{8'h05, 8'h00, 8'hFF, 8'h7F};
    logic       cv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] dv[4] = '{8'hFE, 8'hFF, 8'h00, 8'h00};
    logic       ov[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       zv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] diff;
    logic bout, zero;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op8(av[i], bv[i], cv[i], 0, diff, bout, zero, lat);
      checks++;
      if ({diff, bout, zero} !== {dv[i], ov[i], zv[i]} || lat !== 8) begin
        errors++;
        $display("[TB] FAIL directed%0d got diff=%h bout=%b zero=%b lat=%0d exp diff=%h bout=%b zero=%b lat=8",
                 i, diff, bout, zero, lat, dv[i], ov[i], zv[i]);
      end
    end
  endtask

  task automatic test_hold_stall();
    int lat = 0;
    int seen = 0;
    @(negedge clk);
    bus8.a = 8'h40; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1; bus8.in_valid = 1'b0;
    while (!bus8.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus8.in_valid = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.bin = 1'b1; end
      if (i == 3) bus8.in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus8.out_valid, bus8.in_ready, bus8.diff, bus8.bout, bus8.zero} !== {1'b1, 1'b0, 8'h2F, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_stall%0d got vld=%b rdy=%b diff=%h bout=%b zero=%b exp 1 0 2f 0 0",
                 i, bus8.out_valid, bus8.in_ready, bus8.diff, bus8.bout, bus8.zero);
      end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    checks++;
    if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL hold_release got vld=%b rdy=%b exp 0 1", bus8.out_valid, bus8.in_ready);
    end
    repeat (12) begin @(posedge clk); #1; if (bus8.out_valid || !bus8.in_ready) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL hold_no_capture busy cycles got %0d exp 0", seen); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] diff;
    logic bout, zero;
    int lat;
    int seen = 0;
    @(negedge clk);
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1; bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.diff, bus8.bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL abort_reset got rdy=%b vld=%b diff=%h bout=%b exp 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.diff, bus8.bout);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (bus8.out_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_result out_valid cycles got %0d exp 0", seen); end
    run_op8(8'd9, 8'd4, 1'b0, 1, diff, bout, zero, lat);
    checks++;
    if ({diff, bout, zero} !== {8'h05, 1'b0, 1'b0} || lat !== 8) begin
      errors++; $display("[TB] FAIL abort_next got %h/%b/%b lat=%0d exp 05/0/0 lat=8", diff, bout, zero, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, diff;
    logic bin, bout, zero;
    int lat;
    int unsigned ed;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (i % 8 == 0) b = a;
      run_op8(a, b, bin, int'($urandom_range(0, 3)), diff, bout, zero, lat);
      ed = ref_diff(a, b, bin, 8);
      checks++;
      if (diff !== 8'(ed) || bout !== ref_bout(a, b, bin) || zero !== (ed == 0) || lat !== 8) begin
        errors++;
        $display("[TB] FAIL random a=%h b=%h bin=%b got %h/%b/%b lat=%0d exp %h/%b/%b lat=8",
                 a, b, bin, diff, bout, zero, lat, 8'(ed), ref_bout(a, b, bin), ed == 0);
      end
    end
  endtask

  // Operands change every cycle and out_ready stays high, including while idle.
  task automatic test_back_to_back();
    int unsigned exp_q[$];
    int prev = -1;
    int results = 0;
    int c = 0;
    bus8.out_ready = 1'b1;
    while (c < 90 && (c < 42 || exp_q.size() != 0)) begin
      @(posedge clk); #1;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      bus8.in_valid = (c < 42);
      @(negedge clk);
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back({ref_bout(bus8.a, bus8.b, bus8.bin), 8'(ref_diff(bus8.a, bus8.b, bus8.bin, 8))});
        if (prev >= 0) begin
          checks++;
          if (c - prev !== 10) begin errors++; $display("[TB] FAIL b2b_spacing got %0d exp 10", c - prev); end
        end
        prev = c;
      end
      if (bus8.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_unexpected got diff=%h exp no result", bus8.diff);
        end else if ({bus8.bout, bus8.diff} !== 9'(exp_q[0])) begin
          errors++; $display("[TB] FAIL b2b_result got %b/%h exp %b/%h",
                             bus8.bout, bus8.diff, exp_q[0][8], exp_q[0][7:0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        results++;
      end
      c++;
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    checks++;
    if (results !== 5 || exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL b2b_count got %0d results exp 5", results);
    end
  endtask

  task automatic test_exhaustive3();
    logic [2:0] diff;
    logic bout;
    int lat;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int bin = 0; bin < 2; bin++) begin
          run_op3(3'(a), 3'(b), 1'(bin), diff, bout, lat);
          checks++;
          if (diff !== 3'(ref_diff(a, b, bin, 3)) || bout !== ref_bout(a, b, bin) || lat !== 3) begin
            errors++;
            $display("[TB] FAIL exh3 a=%0d b=%0d bin=%0d got %0d/%b lat=%0d exp %0d/%b lat=3",
                     a, b, bin, diff, bout, lat, ref_diff(a, b, bin, 3), ref_bout(a, b, bin));
          end
        end
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.a = '0; bus3.b = '0; bus3.bin = 1'b0;
    test_reset();
    test_first_accept();
    test_directed();
    test_hold_stall();
    test_reset_abort();
    test_random();
    test_back_to_back();
    test_exhaustive3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
